instr_stream_loader: RTL and testbench

- Upstream feeder for Simple_Single_CPU: receives a program image as a byte stream, writes it word-by-word into instruction memory, and holds the CPU in reset until the image passes its checksum.
- Sits between the host byte link and the IM write port plus the CPU reset input.
- Replaces file preload of IM; also provides a synthesizable load path.

---
 rtl/loader_pkg.sv | 6 +
 rtl/instr_stream_loader_if.sv | 21 ++
 rtl/instr_word_packer.sv | 27 ++
 rtl/instr_stream_loader.sv | 76 +++++++
 tb/tb_instr_stream_loader.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared FSM states and framing constants for the instruction stream loader.
package loader_pkg;
  typedef enum logic [2:0] {HDR_HI, HDR_LO, PAYLOAD, CSUM, RUN, ERROR} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W = 8;
endpackage

// File: rtl/instr_stream_loader_if.sv
// loader_if: host byte link in, IM write port and CPU control out.
interface loader_if #(parameter int CNT_W = 16);
  logic rx_valid_i;
  logic [7:0] rx_data_i;
  logic rx_ready_o;
  logic im_we_o;
  logic [31:0] im_addr_o;
  logic [31:0] im_wdata_o;
  logic cpu_rst_n_o;
  logic done_o;
  logic err_o;
  logic [CNT_W-1:0] words_loaded_o;
  modport master (
    output rx_valid_i, rx_data_i,
    input rx_ready_o, im_we_o, im_addr_o, im_wdata_o, cpu_rst_n_o, done_o, err_o, words_loaded_o
  );
  modport slave (
    input rx_valid_i, rx_data_i,
    output rx_ready_o, im_we_o, im_addr_o, im_wdata_o, cpu_rst_n_o, done_o, err_o, words_loaded_o
  );
endinterface

// File: rtl/instr_word_packer.sv
// instr_word_packer: little-endian byte-to-word assembly with a one-cycle word_valid on the last lane.
module instr_word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);
  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  logic [LANE_W-1:0] lane;
  logic [8*(BYTES_PER_WORD-1)-1:0] shreg;
  always_ff @(posedge clk) begin
    if (clr) begin
      lane <= '0;
      shreg <= '0;
    end else if (en) begin
      lane <= lane + LANE_W'(1);
      shreg <= {data, shreg[8*(BYTES_PER_WORD-1)-1:8]};
    end
  end
  // the final byte lands in the top lane without waiting for a register stage
  assign word = {data, shreg};
  assign word_valid = en && lane == LANE_W'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/instr_stream_loader.sv
// instr_stream_loader: loads a checksummed byte-stream image into IM and releases the CPU on success.
module instr_stream_loader
  import loader_pkg::*;
#(
  parameter int IM_DEPTH = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W = 16
) (
  input logic clk_i,
  input logic rst_n,
  loader_if.slave bus
);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  state_t state, next;
  logic live, acc, timed, timeout, word_valid;
  logic [CNT_W-1:0] count, hdr_cnt;
  logic [CSUM_W-1:0] sum, sum_nxt;
  logic [IDLE_W-1:0] idle;
  logic [31:0] word;
  assign acc = bus.rx_valid_i && bus.rx_ready_o;
  assign timed = state inside {HDR_LO, PAYLOAD, CSUM};
  assign timeout = timed && !acc && idle == IDLE_W'(TIMEOUT_CYC - 1);
  assign hdr_cnt = {count[CNT_W-9:0], bus.rx_data_i};
  assign sum_nxt = sum + bus.rx_data_i;
  instr_word_packer packer (
    .clk(clk_i),
    .clr(!rst_n || state != PAYLOAD),
    .en(acc && state == PAYLOAD),
    .data(bus.rx_data_i),
    .word,
    .word_valid
  );
  always_ff @(posedge clk_i) state <= !rst_n ? HDR_HI : next;
  always_comb begin
    next = state;
    if (timeout) next = ERROR;
    else if (acc)
      case (state)
        HDR_HI:  next = HDR_LO;
        HDR_LO:  next = hdr_cnt > CNT_W'(IM_DEPTH) ? ERROR : hdr_cnt == '0 ? CSUM : PAYLOAD;
        PAYLOAD: next = word_valid && bus.words_loaded_o + CNT_W'(1) == count ? CSUM : PAYLOAD;
        CSUM:    next = sum_nxt == '0 ? RUN : ERROR;
        default: next = state;
      endcase
  end
  // live keeps rx_ready low through the reset cycle itself
  always_comb begin
    bus.rx_ready_o = live && (state == HDR_HI || timed);
    bus.done_o = state == RUN;
    bus.err_o = state == ERROR;
    bus.cpu_rst_n_o = state == RUN;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      live <= 1'b0;
      count <= '0;
      sum <= '0;
      idle <= '0;
      bus.im_we_o <= 1'b0;
      bus.im_addr_o <= '0;
      bus.im_wdata_o <= '0;
      bus.words_loaded_o <= '0;
    end else begin
      live <= 1'b1;
      bus.im_we_o <= word_valid;
      if (acc) sum <= sum_nxt;
      if (acc && (state == HDR_HI || state == HDR_LO)) count <= hdr_cnt;
      idle <= acc || !timed ? '0 : idle + IDLE_W'(1);
      if (word_valid) begin
        bus.im_addr_o <= 32'({bus.words_loaded_o, 2'b00});
        bus.im_wdata_o <= word;
        bus.words_loaded_o <= bus.words_loaded_o + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_instr_stream_loader.sv
// tb_instr_stream_loader: randomized frames against a frame-level reference model with a write/result scoreboard.
module tb_instr_stream_loader;
  localparam int TO = 1024;
  localparam int DEPTH = 32;
  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  typedef struct {bit done; int words;} res_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  wr_t wr_q[$];
  res_t res_q[$];
  always #5 clk = ~clk;
  loader_if bus ();
  instr_stream_loader dut (.clk_i(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Frame-level model: walks the byte list and predicts writes and the final verdict.
  task automatic model(input logic [7:0] b[$], input int g[$], output bit term);
    int cnt = 0;
    int nw = 0;
    logic [7:0] s = 8'h00;
    term = 1'b0;
    for (int i = 0; i < b.size(); i++) begin
      if (i > 0 && g[i] >= TO) begin
        res_q.push_back('{1'b0, nw});
        return;
      end
      s = s + b[i];
      if (i == 1) begin
        cnt = {b[0], b[1]};
        if (cnt > DEPTH) begin
          res_q.push_back('{1'b0, nw});
          term = 1'b1;
          return;
        end
      end
      if (i >= 2 && i < 2 + 4 * cnt && (i - 2) % 4 == 3) begin
        wr_q.push_back('{32'(nw * 4), {b[i], b[i-1], b[i-2], b[i-3]}});
        nw++;
      end
      if (i >= 2 && i == 2 + 4 * cnt) begin
        res_q.push_back('{s == 8'h00, nw});
        term = 1'b1;
        return;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap, output bit ok);
    bus.rx_valid_i = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i = v;
    @(negedge clk);
    ok = bus.rx_ready_o;
    @(posedge clk);
    #1;
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b[$], input int g[$]);
    bit term, ok;
    model(b, g, term);
    ok = 1'b1;
    for (int i = 0; i < b.size() && ok; i++) send_byte(b[i], g[i], ok);
    if (ok && term) chk("verdict_latency", 32'(bus.done_o | bus.err_o), 32'd1);
  endtask

  task automatic build(input int cnt, input bit good, input int gap, output logic [7:0] b[$], output int g[$]);
    logic [7:0] s;
    logic [31:0] w;
    b = {8'(cnt >> 8), 8'(cnt)};
    if (cnt <= DEPTH) begin
      for (int k = 0; k < cnt; k++) begin
        w = $urandom;
        for (int j = 0; j < 4; j++) b.push_back(w[8*j +: 8]);
      end
      s = 8'h00;
      foreach (b[k]) s = s + b[k];
      s = 8'h00 - s;
      b.push_back(good ? s : s ^ 8'h01);
    end
    g = {};
    foreach (b[k]) g.push_back(gap);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i = 8'h00;
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.rx_ready_o), 0);
    chk("rst_we", 32'(bus.im_we_o), 0);
    chk("rst_addr", bus.im_addr_o, 0);
    chk("rst_wdata", bus.im_wdata_o, 0);
    chk("rst_cpu", 32'(bus.cpu_rst_n_o), 0);
    chk("rst_done", 32'(bus.done_o), 0);
    chk("rst_err", 32'(bus.err_o), 0);
    chk("rst_words", 32'(bus.words_loaded_o), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(bus.rx_ready_o), 1);
  endtask

  // Monitor: pops expected writes on each strobe and expected verdicts on each done/err rise.
  initial begin
    bit prev_we = 1'b0;
    bit prev_term = 1'b0;
    wr_t w;
    res_t r;
    forever begin
      @(negedge clk);
      if (bus.im_we_o) begin
        chk("we_not_back_to_back", 32'(prev_we), 0);
        if (wr_q.size() == 0) chk("spurious_we", 32'(bus.im_we_o), 0);
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", bus.im_addr_o, w.addr);
          chk("wr_data", bus.im_wdata_o, w.data);
        end
      end
      if ((bus.done_o || bus.err_o) && !prev_term) begin
        if (res_q.size() == 0) chk("spurious_verdict", 32'(bus.done_o | bus.err_o), 0);
        else begin
          r = res_q.pop_front();
          chk("done", 32'(bus.done_o), 32'(r.done));
          chk("err", 32'(bus.err_o), 32'(!r.done));
          chk("cpu_rst_n", 32'(bus.cpu_rst_n_o), 32'(r.done));
          chk("words_loaded", 32'(bus.words_loaded_o), 32'(r.words));
          chk("ready_after_verdict", 32'(bus.rx_ready_o), 0);
        end
      end
      prev_we = bus.im_we_o;
      prev_term = bus.done_o || bus.err_o;
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [7:0] b[$];
    int g[$];
    bit ok;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i = 8'h00;
    do_reset();
    b = {8'h00, 8'h01, 8'h05, 8'h00, 8'h01, 8'h20, 8'hD9};
    g = {0, 0, 0, 0, 0, 0, 0};
    send_frame(b, g);
    do_reset();
    b = {8'h00, 8'h01, 8'h05, 8'h00, 8'h01, 8'h20, 8'hD8};
    send_frame(b, g);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0, ok);
    chk("err_sticky", 32'(bus.err_o), 1);
    chk("done_after_bad", 32'(bus.done_o), 0);
    do_reset();
    b = {8'h00, 8'h21};
    g = {0, 0};
    send_frame(b, g);
    do_reset();
    b = {8'h00, 8'h00, 8'h00};
    g = {0, 0, 0};
    send_frame(b, g);
    do_reset();
    build(3, 1'b1, 3, b, g);
    send_frame(b, g);
    do_reset();
    build(3, 1'b1, 3, b, g);
    g[7] = TO;
    send_frame(b, g);
    do_reset();
    build(4, 1'b1, 0, b, g);
    b = b[0:9];
    g = g[0:9];
    send_frame(b, g);
    do_reset();
    build(1, 1'b1, 0, b, g);
    send_frame(b, g);
    for (int n = 0; n < 24; n++) begin
      do_reset();
      build($urandom_range(0, 35), $urandom_range(0, 4) != 0, 0, b, g);
      foreach (g[k]) g[k] = $urandom_range(0, 30) == 0 ? 1000 : $urandom_range(0, 2);
      if ($urandom_range(0, 5) == 0) g[$urandom_range(1, b.size() - 1)] = TO + $urandom_range(0, 20);
      send_frame(b, g);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("wr_q_drained", 32'(wr_q.size()), 0);
    chk("res_q_drained", 32'(res_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
